// File: rtl/hetic_pkg.sv
// hetic arbitration types, sizes and the candidate compare.
// Shared by the reduction tree and the arbiter stage.
package hetic_pkg;

  localparam int unsigned NrIrqLines  = 64;
  localparam int unsigned NrIrqPrios  = 32;
  localparam int unsigned IrqWidth    = $clog2(NrIrqLines);
  localparam int unsigned PrioWidth   = $clog2(NrIrqPrios);
  localparam int unsigned DrainCycles = 2;
  localparam int unsigned CntWidth    = $clog2(DrainCycles + 1);

  typedef struct packed {
    logic                 valid;
    logic [IrqWidth-1:0]  id;
    logic [PrioWidth-1:0] prio;
    logic                 heti;
    logic                 nest;
  } irq_cand_t;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    DRAIN
  } arb_state_e;

  function automatic logic cand_wins(irq_cand_t a, irq_cand_t b);
    if (a.valid != b.valid) return a.valid;
    if (a.prio != b.prio) return a.prio > b.prio;
    return a.id <= b.id;
  endfunction

endpackage

// File: rtl/hetic_arb_tree.sv
// Balanced log2(N)-deep winner reduction over candidates.
// Left subtrees always hold lower ids, so ties fall to the left.
module hetic_arb_tree
  import hetic_pkg::*;
#(
  parameter int unsigned N = NrIrqLines
) (
  input  irq_cand_t cands [N],
  output irq_cand_t winner
);

  localparam int unsigned Depth = $clog2(N);

  for (genvar l = 0; l <= Depth; l++) begin : g_lvl
    irq_cand_t node [N >> l];
    if (l == 0) begin : g_leaf
      assign node = cands;
    end else begin : g_red
      for (genvar k = 0; k < (N >> l); k++) begin : g_node
        assign node[k] =
          cand_wins(g_lvl[l-1].node[2*k], g_lvl[l-1].node[2*k+1])
            ? g_lvl[l-1].node[2*k]
            : g_lvl[l-1].node[2*k+1];
      end
    end
  end

  assign winner = g_lvl[Depth].node[0];

endmodule

// File: rtl/hetic_arbiter.sv
// hetic arbitration and claim stage: picks the best eligible line,
// offers it to the core and issues the pending-clear on a claim.
module hetic_arbiter
  import hetic_pkg::*;
(
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NrIrqLines-1:0]                line_ie_i,
  input  logic [NrIrqLines-1:0]                line_ip_i,
  input  logic [NrIrqLines-1:0]                line_heti_i,
  input  logic [NrIrqLines-1:0]                line_nest_i,
  input  logic [NrIrqLines-1:0][PrioWidth-1:0] line_prio_i,
  input  logic [PrioWidth-1:0]                 thresh_i,
  output logic                                 irq_valid_o,
  output logic [IrqWidth-1:0]                  irq_id_o,
  output logic [PrioWidth-1:0]                 irq_prio_o,
  output logic                                 irq_heti_o,
  output logic                                 irq_nest_o,
  input  logic                                 irq_ack_i,
  input  logic [IrqWidth-1:0]                  irq_id_i,
  output logic                                 clr_valid_o,
  output logic [IrqWidth-1:0]                  clr_id_o,
  output logic                                 ack_err_o
);

  irq_cand_t cands [NrIrqLines];
  irq_cand_t tree_win;
  irq_cand_t cand_q;
  irq_cand_t offer_q, offer_d;

  arb_state_e          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                clr_valid_q, clr_valid_d;
  logic [IrqWidth-1:0] clr_id_q, clr_id_d;
  logic                ack_err_q, ack_err_d;

  always_comb begin
    for (int i = 0; i < NrIrqLines; i++) begin
      cands[i].valid = line_ie_i[i] & line_ip_i[i]
                     & (line_prio_i[i] > thresh_i);
      cands[i].id    = IrqWidth'(i);
      cands[i].prio  = line_prio_i[i];
      cands[i].heti  = line_heti_i[i];
      cands[i].nest  = line_nest_i[i];
    end
  end

  hetic_arb_tree #(
    .N(NrIrqLines)
  ) u_tree (
    .cands (cands),
    .winner(tree_win)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) cand_q <= '0;
    else       cand_q <= tree_win;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      offer_q     <= '0;
      clr_valid_q <= 1'b0;
      clr_id_q    <= '0;
      ack_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      offer_q     <= offer_d;
      clr_valid_q <= clr_valid_d;
      clr_id_q    <= clr_id_d;
      ack_err_q   <= ack_err_d;
    end
  end

  // A claim wins over a same-cycle preemption or withdrawal.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    offer_d     = offer_q;
    clr_valid_d = 1'b0;
    clr_id_d    = '0;
    ack_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ack_err_d = irq_ack_i;
        if (cand_q.valid) begin
          offer_d = cand_q;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (irq_ack_i && irq_id_i == offer_q.id) begin
          clr_valid_d = 1'b1;
          clr_id_d    = offer_q.id;
          offer_d     = '0;
          cnt_d       = CntWidth'(DrainCycles);
          state_d     = DRAIN;
        end else if (irq_ack_i) begin
          ack_err_d = 1'b1;
        end else if (!cand_q.valid) begin
          offer_d = '0;
          state_d = IDLE;
        end else begin
          offer_d = cand_q;
        end
      end
      DRAIN: begin
        ack_err_d = irq_ack_i;
        if (cnt_q <= CntWidth'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign irq_valid_o = offer_q.valid;
  assign irq_id_o    = offer_q.id;
  assign irq_prio_o  = offer_q.prio;
  assign irq_heti_o  = offer_q.heti;
  assign irq_nest_o  = offer_q.nest;
  assign clr_valid_o = clr_valid_q;
  assign clr_id_o    = clr_id_q;
  assign ack_err_o   = ack_err_q;

endmodule

// File: tb/tb_hetic_arbiter.sv
// Scenario bench for hetic_arbiter with an emulated register file
// and a queue of expected clear ids.
module tb_hetic_arbiter;
  import hetic_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NrIrqLines-1:0] ie = '0;
  logic [NrIrqLines-1:0] ip = '0;
  logic [NrIrqLines-1:0] heti = '0;
  logic [NrIrqLines-1:0] nest = '0;
  logic [NrIrqLines-1:0][PrioWidth-1:0] prio = '0;
  logic [PrioWidth-1:0] thresh = '0;
  logic                 ack = 1'b0;
  logic [IrqWidth-1:0]  ack_id = '0;
  logic                 irq_valid;
  logic [IrqWidth-1:0]  irq_id;
  logic [PrioWidth-1:0] irq_prio;
  logic                 irq_heti;
  logic                 irq_nest;
  logic                 clr_valid;
  logic [IrqWidth-1:0]  clr_id;
  logic                 ack_err;

  int total = 0;
  int bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  hetic_arbiter dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .line_ie_i  (ie),
    .line_ip_i  (ip),
    .line_heti_i(heti),
    .line_nest_i(nest),
    .line_prio_i(prio),
    .thresh_i   (thresh),
    .irq_valid_o(irq_valid),
    .irq_id_o   (irq_id),
    .irq_prio_o (irq_prio),
    .irq_heti_o (irq_heti),
    .irq_nest_o (irq_nest),
    .irq_ack_i  (ack),
    .irq_id_i   (ack_id),
    .clr_valid_o(clr_valid),
    .clr_id_o   (clr_id),
    .ack_err_o  (ack_err)
  );

  function automatic void ref_win(output bit v, output int id,
                                  output int p);
    v = 0; id = 0; p = 0;
    for (int i = 0; i < NrIrqLines; i++) begin
      if (ie[i] && ip[i] && prio[i] > thresh) begin
        if (!v || int'(prio[i]) > p) begin
          v = 1; id = i; p = int'(prio[i]);
        end
      end
    end
  endfunction

  // One clock; also acts as the register file clearing ip on clr.
  task automatic step();
    bit c;
    int cid;
    int e;
    c = (clr_valid === 1'b1);
    cid = int'(clr_id);
    @(posedge clk);
    #1;
    if (c) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL clr_unexpected: got clr id %0d, wanted none",
                 cid);
      end else begin
        e = exp_q.pop_front();
        if (cid !== e) begin
          bad++;
          $display("FAIL clr_id: got %0d, wanted %0d", cid, e);
        end
      end
      ip[cid] = 1'b0;
    end
    total++;
    if (clr_valid === 1'b1 && irq_valid === 1'b1) begin
      bad++;
      $display("FAIL clr_excl: clr_valid=1 irq_valid=1, wanted not both");
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_lines();
    ie = '0; ip = '0; prio = '0; heti = '0; nest = '0; thresh = '0;
    steps(4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    steps(2);
    total++;
    if ({irq_valid, irq_id, irq_prio, irq_heti, irq_nest,
         clr_valid, clr_id, ack_err} !== '0) begin
      bad++;
      $display("FAIL reset_outs: valid=%b id=%0d clr=%b err=%b, wanted 0",
               irq_valid, irq_id, clr_valid, ack_err);
    end
    rst = 1'b0;
    steps(2);
    total++;
    if (irq_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: valid=%b, wanted 0", irq_valid);
    end
  endtask

  task automatic test_single();
    ie[5] = 1'b1; prio[5] = 5'd3; heti[5] = 1'b1; thresh = '0;
    step();
    ip[5] = 1'b1;
    step();
    total++;
    if (irq_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_lat1: valid=%b, wanted 0", irq_valid);
    end
    step();
    total++;
    if ({irq_valid, irq_id, irq_prio, irq_heti, irq_nest} !==
        {1'b1, 6'd5, 5'd3, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL single_offer: v=%b id=%0d p=%0d h=%b n=%b, want 1/5/3/1/0",
               irq_valid, irq_id, irq_prio, irq_heti, irq_nest);
    end
    ack = 1'b1; ack_id = 6'd5; exp_q.push_back(5);
    step();
    ack = 1'b0;
    total++;
    if ({irq_valid, clr_valid, ack_err} !== 3'b010) begin
      bad++;
      $display("FAIL single_claim: v=%b clr=%b err=%b, wanted 0/1/0",
               irq_valid, clr_valid, ack_err);
    end
    step();
    total++;
    if (clr_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_clr_pulse: clr=%b, wanted 0", clr_valid);
    end
    clear_lines();
  endtask

  task automatic test_tie();
    ie[2] = 1; ie[9] = 1; ie[40] = 1;
    prio[2] = 5'd7; prio[9] = 5'd7; prio[40] = 5'd6;
    ip[2] = 1; ip[9] = 1; ip[40] = 1;
    steps(2);
    total++;
    if ({irq_valid, irq_id, irq_prio} !== {1'b1, 6'd2, 5'd7}) begin
      bad++;
      $display("FAIL tie_first: v=%b id=%0d p=%0d, wanted 1/2/7",
               irq_valid, irq_id, irq_prio);
    end
    ack = 1'b1; ack_id = 6'd2; exp_q.push_back(2);
    step();
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (irq_valid !== 1'b0) begin
        bad++;
        $display("FAIL tie_drain%0d: valid=%b, wanted 0", i, irq_valid);
      end
      step();
    end
    total++;
    if ({irq_valid, irq_id, irq_prio} !== {1'b1, 6'd9, 5'd7}) begin
      bad++;
      $display("FAIL tie_second: v=%b id=%0d p=%0d, wanted 1/9/7",
               irq_valid, irq_id, irq_prio);
    end
    clear_lines();
  endtask

  task automatic test_thresh();
    ie[3] = 1; prio[3] = 5'd4; ip[3] = 1; thresh = 5'd4;
    steps(3);
    total++;
    if (irq_valid !== 1'b0) begin
      bad++;
      $display("FAIL thresh_block: valid=%b, wanted 0", irq_valid);
    end
    thresh = 5'd3;
    steps(2);
    total++;
    if ({irq_valid, irq_id} !== {1'b1, 6'd3}) begin
      bad++;
      $display("FAIL thresh_pass: v=%b id=%0d, wanted 1/3",
               irq_valid, irq_id);
    end
  endtask

  task automatic test_ack_err();
    ack = 1'b1; ack_id = 6'd7;
    step();
    ack = 1'b0;
    total++;
    if ({ack_err, irq_valid, irq_id, clr_valid} !==
        {1'b1, 1'b1, 6'd3, 1'b0}) begin
      bad++;
      $display("FAIL ack_err: err=%b v=%b id=%0d clr=%b, wanted 1/1/3/0",
               ack_err, irq_valid, irq_id, clr_valid);
    end
    step();
    total++;
    if (ack_err !== 1'b0) begin
      bad++;
      $display("FAIL ack_err_pulse: err=%b, wanted 0", ack_err);
    end
  endtask

  task automatic test_preempt();
    ie[20] = 1; ip[20] = 1; prio[20] = 5'd10;
    step();
    total++;
    if ({irq_valid, irq_id} !== {1'b1, 6'd3}) begin
      bad++;
      $display("FAIL preempt_hold: v=%b id=%0d, wanted 1/3",
               irq_valid, irq_id);
    end
    step();
    total++;
    if ({irq_valid, irq_id, irq_prio} !== {1'b1, 6'd20, 5'd10}) begin
      bad++;
      $display("FAIL preempt_swap: v=%b id=%0d p=%0d, wanted 1/20/10",
               irq_valid, irq_id, irq_prio);
    end
  endtask

  task automatic test_withdraw();
    ie[3] = 0; ie[20] = 0;
    step();
    total++;
    if (irq_valid !== 1'b1) begin
      bad++;
      $display("FAIL withdraw_hold: valid=%b, wanted 1", irq_valid);
    end
    step();
    total++;
    if ({irq_valid, clr_valid} !== 2'b00) begin
      bad++;
      $display("FAIL withdraw_drop: v=%b clr=%b, wanted 0/0",
               irq_valid, clr_valid);
    end
    clear_lines();
  endtask

  task automatic test_simul();
    ie[3] = 1; prio[3] = 5'd4; ip[3] = 1; thresh = 5'd3;
    steps(2);
    ie[20] = 1; ip[20] = 1; prio[20] = 5'd10;
    step();
    ack = 1'b1; ack_id = 6'd3; exp_q.push_back(3);
    step();
    ack = 1'b0;
    total++;
    if ({irq_valid, clr_valid, clr_id} !== {1'b0, 1'b1, 6'd3}) begin
      bad++;
      $display("FAIL simul_claim: v=%b clr=%b cid=%0d, wanted 0/1/3",
               irq_valid, clr_valid, clr_id);
    end
    for (int i = 0; i < DrainCycles; i++) begin
      step();
      total++;
      if (irq_valid !== 1'b0) begin
        bad++;
        $display("FAIL simul_drain%0d: valid=%b, wanted 0", i, irq_valid);
      end
    end
    step();
    total++;
    if ({irq_valid, irq_id} !== {1'b1, 6'd20}) begin
      bad++;
      $display("FAIL simul_next: v=%b id=%0d, wanted 1/20",
               irq_valid, irq_id);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({irq_valid, irq_id, irq_prio, clr_valid, ack_err} !== '0) begin
      bad++;
      $display("FAIL rst_mid: v=%b id=%0d clr=%b err=%b, wanted 0",
               irq_valid, irq_id, clr_valid, ack_err);
    end
    step();
    total++;
    if (irq_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_lat: valid=%b, wanted 0", irq_valid);
    end
    step();
    total++;
    if ({irq_valid, irq_id} !== {1'b1, 6'd20}) begin
      bad++;
      $display("FAIL rst_mid_reoffer: v=%b id=%0d, wanted 1/20",
               irq_valid, irq_id);
    end
    clear_lines();
  endtask

  task automatic test_all_lines();
    ie = '1; ip = '1; thresh = '0;
    for (int i = 0; i < NrIrqLines; i++) prio[i] = 5'd31;
    steps(2);
    total++;
    if ({irq_valid, irq_id, irq_prio} !== {1'b1, 6'd0, 5'd31}) begin
      bad++;
      $display("FAIL all_tie: v=%b id=%0d p=%0d, wanted 1/0/31",
               irq_valid, irq_id, irq_prio);
    end
    for (int i = 0; i < NrIrqLines - 1; i++) prio[i] = 5'd30;
    steps(2);
    total++;
    if ({irq_valid, irq_id, irq_prio} !== {1'b1, 6'd63, 5'd31}) begin
      bad++;
      $display("FAIL all_top: v=%b id=%0d p=%0d, wanted 1/63/31",
               irq_valid, irq_id, irq_prio);
    end
    clear_lines();
  endtask

  task automatic test_random();
    bit v;
    int id;
    int p;
    for (int r = 0; r < 10; r++) begin
      ie = {$urandom, $urandom};
      ip = {$urandom, $urandom};
      heti = {$urandom, $urandom};
      for (int i = 0; i < NrIrqLines; i++)
        prio[i] = PrioWidth'($urandom_range(0, NrIrqPrios - 1));
      thresh = PrioWidth'($urandom_range(0, 28));
      steps(2);
      ref_win(v, id, p);
      total++;
      if (irq_valid !== v ||
          (v && (int'(irq_id) != id || int'(irq_prio) != p ||
                 irq_heti !== heti[id]))) begin
        bad++;
        $display("FAIL rand%0d: v=%b id=%0d p=%0d, wanted v=%b id=%0d p=%0d",
                 r, irq_valid, irq_id, irq_prio, v, id, p);
      end
    end
    clear_lines();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_thresh();
    test_ack_err();
    test_preempt();
    test_withdraw();
    test_simul();
    test_reset_mid();
    test_all_lines();
    test_random();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL clr_missing: %0d clears outstanding, wanted 0",
               exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
